// File: rtl/mod_74x32_gate_fifo.sv
// Multi-channel 2-input gate array (OR/AND/XOR/NOR) feeding a DEPTH-entry valid/ready FIFO.
// Optional head-entry parity output PAR is enabled by defining MOD_74X32_PARITY_EN.
module mod_74x32_gate_fifo #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4
) (
  input  logic                          CLK,
  input  logic                          CLR_N,
  input  logic [CHANNELS*WIDTH-1:0]     A,
  input  logic [CHANNELS*WIDTH-1:0]     B,
  input  logic [1:0]                    FN,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  output logic [CHANNELS*WIDTH-1:0]     Y,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [$clog2(DEPTH+1)-1:0]    LEVEL
`ifdef MOD_74X32_PARITY_EN
  ,
  output logic [CHANNELS-1:0]           PAR
`endif
);

  localparam int BUS_W = CHANNELS * WIDTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  function automatic logic [BUS_W-1:0] gate_fn(input logic [BUS_W-1:0] a,
                                               input logic [BUS_W-1:0] b,
                                               input logic [1:0]       fn);
    logic [BUS_W-1:0] r;
    unique case (fn)
      2'b00:   r = a | b;
      2'b01:   r = a & b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

`ifdef MOD_74X32_PARITY_EN
  function automatic logic [CHANNELS-1:0] chan_parity(input logic [BUS_W-1:0] y);
    logic [CHANNELS-1:0] p;
    for (int c = 0; c < CHANNELS; c++) p[c] = ^y[c*WIDTH +: WIDTH];
    return p;
  endfunction
`endif

  logic [BUS_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [BUS_W-1:0] wr_data_p0;

  assign full       = (level == LVL_W'(DEPTH));
  assign empty      = (level == '0);
  assign push       = IN_VALID && !full;
  assign pop        = OUT_READY && !empty;
  assign wr_data_p0 = gate_fn(A, B, FN);

  // Stage p0 -> storage: function result captured at the push edge, FN sampled with A/B.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_data_p0;
  end

`ifdef MOD_74X32_PARITY_EN
  logic [CHANNELS-1:0] par_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (push) par_mem[wr_ptr] <= chan_parity(wr_data_p0);
  end

  assign PAR = empty ? '0 : par_mem[rd_ptr];
`endif

  // Control state; pointer wrap is explicit so DEPTH need not be a power of two.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign IN_READY  = !full;
  assign OUT_VALID = !empty;
  assign LEVEL     = level;
  assign Y         = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_mod_74x32_gate_fifo.sv
// Directed bench for mod_74x32_gate_fifo (default WIDTH=4, CHANNELS=2, DEPTH=4).
// Connects PAR and checks parity only when MOD_74X32_PARITY_EN is defined.
module tb_mod_74x32_gate_fifo;

  logic       CLK = 1'b0;
  logic       CLR_N;
  logic [7:0] A, B;
  logic [1:0] FN;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] Y;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [2:0] LEVEL;
`ifdef MOD_74X32_PARITY_EN
  logic [1:0] PAR;
`endif

  int vec_count = 0;
  int err_count = 0;

  mod_74x32_gate_fifo #(.WIDTH(4), .CHANNELS(2), .DEPTH(4)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .A(A), .B(B), .FN(FN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .Y(Y),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .LEVEL(LEVEL)
`ifdef MOD_74X32_PARITY_EN
    , .PAR(PAR)
`endif
  );

  always #5 CLK = ~CLK;

  // Inputs change at the falling edge; outputs are sampled at the next falling edge.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] fn, input logic ordy);
    IN_VALID = v; A = a; B = b; FN = fn; OUT_READY = ordy;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    CLR_N = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    repeat (2) @(negedge CLK);
    vec_count++;
    if (LEVEL !== 3'd0) begin err_count++; $display("FAIL reset_level got %0d want 0", LEVEL); end
    vec_count++;
    if (OUT_VALID !== 1'b0) begin err_count++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    vec_count++;
    if (IN_READY !== 1'b1) begin err_count++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    vec_count++;
    if (Y !== 8'h00) begin err_count++; $display("FAIL reset_y got %h want 00", Y); end
    CLR_N = 1'b1;
    step();
  endtask

  task automatic test_single_push();
    drive(1'b1, 8'hF0, 8'h0F, 2'b00, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    vec_count++;
    if (OUT_VALID !== 1'b1) begin err_count++; $display("FAIL push1_out_valid got %b want 1", OUT_VALID); end
    vec_count++;
    if (Y !== 8'hFF) begin err_count++; $display("FAIL push1_y got %h want ff", Y); end
    vec_count++;
    if (LEVEL !== 3'd1) begin err_count++; $display("FAIL push1_level got %0d want 1", LEVEL); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    vec_count++;
    if (LEVEL !== 3'd0 || Y !== 8'h00 || OUT_VALID !== 1'b0) begin
      err_count++; $display("FAIL push1_drain level=%0d y=%h ov=%b want 0/00/0", LEVEL, Y, OUT_VALID);
    end
  endtask

  task automatic test_fn_fill();
    logic [1:0] fns [4];
    fns[0] = 2'b01; fns[1] = 2'b10; fns[2] = 2'b11; fns[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hCC, 8'hAA, fns[i], 1'b0);
      step();
    end
    vec_count++;
    if (LEVEL !== 3'd4) begin err_count++; $display("FAIL fill_level got %0d want 4", LEVEL); end
    vec_count++;
    if (IN_READY !== 1'b0) begin err_count++; $display("FAIL fill_in_ready got %b want 0", IN_READY); end
    vec_count++;
    if (Y !== 8'h88) begin err_count++; $display("FAIL fill_head_and got %h want 88", Y); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] rest [3];
    rest[0] = 8'h66; rest[1] = 8'h11; rest[2] = 8'hEE;
    drive(1'b1, 8'h00, 8'h00, 2'b00, 1'b1);
    step();
    vec_count++;
    if (LEVEL !== 3'd3) begin err_count++; $display("FAIL full_pp_level got %0d want 3", LEVEL); end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      vec_count++;
      if (Y !== rest[i]) begin err_count++; $display("FAIL pop_order_%0d got %h want %h", i, Y, rest[i]); end
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    vec_count++;
    if (LEVEL !== 3'd0 || OUT_VALID !== 1'b0) begin
      err_count++; $display("FAIL full_pp_drain level=%0d ov=%b want 0/0", LEVEL, OUT_VALID);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'd1, 8'h00, 2'b00, 1'b0);
    step();
    drive(1'b1, 8'd2, 8'h00, 2'b00, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      vec_count++;
      if (LEVEL !== 3'd2 || Y !== 8'(i + 1)) begin
        err_count++; $display("FAIL b2b_%0d level=%0d y=%h want 2/%h", i, LEVEL, Y, 8'(i + 1));
      end
      drive(1'b1, 8'(i + 3), 8'h00, 2'b00, 1'b1);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    vec_count++;
    if (LEVEL !== 3'd2 || Y !== 8'd11) begin
      err_count++; $display("FAIL b2b_end level=%0d y=%h want 2/0b", LEVEL, Y);
    end
    step();
    vec_count++;
    if (Y !== 8'd12) begin err_count++; $display("FAIL b2b_tail got %h want 0c", Y); end
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h5A, 8'h00, 2'b00, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    vec_count++;
    if (LEVEL !== 3'd3) begin err_count++; $display("FAIL arst_pre_level got %0d want 3", LEVEL); end
    #2 CLR_N = 1'b0;
    #1;
    vec_count++;
    if (LEVEL !== 3'd0 || OUT_VALID !== 1'b0 || Y !== 8'h00 || IN_READY !== 1'b1) begin
      err_count++;
      $display("FAIL arst_now level=%0d ov=%b y=%h ir=%b want 0/0/00/1", LEVEL, OUT_VALID, Y, IN_READY);
    end
    @(negedge CLK);
    CLR_N = 1'b1;
    step();
  endtask

  task automatic test_parity();
    drive(1'b1, 8'h07, 8'h00, 2'b10, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
    vec_count++;
    if (Y !== 8'h07) begin err_count++; $display("FAIL xor_y got %h want 07", Y); end
`ifdef MOD_74X32_PARITY_EN
    vec_count++;
    if (PAR !== 2'b01) begin err_count++; $display("FAIL par_head got %b want 01", PAR); end
`endif
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);
`ifdef MOD_74X32_PARITY_EN
    vec_count++;
    if (PAR !== 2'b00) begin err_count++; $display("FAIL par_empty got %b want 00", PAR); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fn_fill();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
